// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: decode/execute qualifiers and store traffic in, pipeline
// hold/kill controls and status out.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
);
    logic             id_valid;
    logic             id_has_rs1;
    logic             id_has_rs2;
    logic             id_is_store;
    logic             id_is_fence;
    logic             id_is_system;
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;

    logic             ex_valid;
    logic             ex_is_load;
    logic [4:0]       ex_rd;
    logic             ex_redirect;

    logic             st_issue;
    logic             st_ack;

    logic             stall_if;
    logic             stall_id;
    logic             bubble_ex;
    logic             flush_id;
    logic             drain_busy;
    logic [CNT_W-1:0] st_count;
    logic             proto_err;

    // Pipeline side: presents stage information, obeys the hold/kill controls.
    modport master (
        output id_valid, id_has_rs1, id_has_rs2, id_is_store, id_is_fence, id_is_system,
        output id_rs1, id_rs2,
        output ex_valid, ex_is_load, ex_rd, ex_redirect,
        output st_issue, st_ack,
        input  stall_if, stall_id, bubble_ex, flush_id, drain_busy, st_count, proto_err
    );

    // Controller side.
    modport slave (
        input  id_valid, id_has_rs1, id_has_rs2, id_is_store, id_is_fence, id_is_system,
        input  id_rs1, id_rs2,
        input  ex_valid, ex_is_load, ex_rd, ex_redirect,
        input  st_issue, st_ack,
        output stall_if, stall_id, bubble_ex, flush_id, drain_busy, st_count, proto_err
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// In-order pipeline hazard controller: load-use and store-buffer backpressure stalls,
// fence/system drain sequencing, redirect flush, and outstanding-store accounting.
module pipeline_hazard_ctrl #(
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StRelease
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] st_count_q, st_count_d;
    logic             proto_err_q, proto_err_d;

    logic load_use;
    logic store_full;
    logic drain_req;
    logic drained;
    logic hold;
    logic bubble;
    logic flush;

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    always_comb begin
        load_use   = bus.ex_valid & bus.ex_is_load & (bus.ex_rd != 5'd0) & bus.id_valid &
                     ((bus.id_has_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                      (bus.id_has_rs2 & (bus.id_rs2 == bus.ex_rd)));
        store_full = bus.id_valid & bus.id_is_store & (st_count_q == MaxCnt);
        drain_req  = bus.id_valid & (bus.id_is_fence | bus.id_is_system);
        drained    = (st_count_q == '0) & ~bus.ex_valid;
    end

    // ------------------------------------------------------------------
    // Drain FSM and stall/flush decode
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        hold    = 1'b0;
        bubble  = 1'b0;
        flush   = 1'b0;

        if (bus.ex_redirect) begin
            // Redirect wins over everything: kill the wrong-path decode, keep fetching.
            state_d = StIdle;
            flush   = 1'b1;
            bubble  = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (drain_req) begin
                        state_d = StDrain;
                    end
                    if (load_use | store_full) begin
                        hold   = 1'b1;
                        bubble = 1'b1;
                    end
                end
                StDrain: begin
                    hold   = 1'b1;
                    bubble = 1'b1;
                    if (drained) begin
                        state_d = StRelease;
                    end
                end
                StRelease: begin
                    // One free cycle lets the fence/system op leave ID without re-arming.
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-store counter
    // ------------------------------------------------------------------
    always_comb begin
        st_count_d  = st_count_q;
        proto_err_d = proto_err_q;
        case ({bus.st_issue, bus.st_ack})
            2'b10: begin
                if (st_count_q == MaxCnt) begin
                    proto_err_d = 1'b1;
                end else begin
                    st_count_d = st_count_q + 1'b1;
                end
            end
            2'b01: begin
                if (st_count_q == '0) begin
                    proto_err_d = 1'b1;
                end else begin
                    st_count_d = st_count_q - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            st_count_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_count_q  <= st_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs; combinational controls are quiet while reset is held
    // ------------------------------------------------------------------
    assign bus.stall_if   = hold & ~rst;
    assign bus.stall_id   = hold & ~rst;
    assign bus.bubble_ex  = bubble & ~rst;
    assign bus.flush_id   = flush & ~rst;
    assign bus.drain_busy = (state_q != StIdle);
    assign bus.st_count   = st_count_q;
    assign bus.proto_err  = proto_err_q;

    // ------------------------------------------------------------------
    // Invariants
    // ------------------------------------------------------------------
    a_count_bounded: assert property (@(posedge clk) disable iff (rst)
        st_count_q <= MaxCnt);

    a_release_one_cycle: assert property (@(posedge clk) disable iff (rst)
        (state_q == StRelease) |=> (state_q == StIdle));

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of stores issued to memory and not yet acknowledged.
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_OUTSTANDING+1), meaning the width of the outstanding-store counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock; one clock domain.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports id_valid, id_has_rs1, id_has_rs2, id_is_store, id_is_fence, id_is_system  input  1 each  decode-stage qualifiers.
REQ-006 SHALL have ports id_rs1, id_rs2  input  5 each  decode-stage source registers.
REQ-007 SHALL have ports ex_valid, ex_is_load  input  1 each, and ex_rd  input  5; these give EX-stage occupancy, load flag and destination.
REQ-008 SHALL have port ex_redirect  input  1  branch or jump resolved taken in EX.
REQ-009 SHALL have ports st_issue, st_ack  input  1 each  store issued to memory, store acknowledged by memory.
REQ-010 SHALL have ports stall_if, stall_id  output  1 each  hold PC and IF/ID.
REQ-011 SHALL have ports bubble_ex  output  1  insert NOP into ID/EX, and flush_id  output  1  kill IF/ID contents.
REQ-012 SHALL have ports drain_busy  output  1  FSM not in IDLE; st_count  output  CNT_W  outstanding stores; proto_err  output  1  sticky protocol error.

Function
REQ-013 SHALL implement FSM states IDLE, DRAIN and RELEASE.
REQ-014 SHALL flag load-use when ex_valid & ex_is_load & ex_rd!=0 & id_valid & ((id_has_rs1 & id_rs1==ex_rd) | (id_has_rs2 & id_rs2==ex_rd)).
REQ-015 SHALL flag store_full when id_valid & id_is_store & st_count==MAX_OUTSTANDING.
REQ-016 SHALL transition IDLE->DRAIN when id_valid & (id_is_fence | id_is_system) & !ex_redirect.
REQ-017 SHALL transition DRAIN->RELEASE in the cycle after st_count==0 & !ex_valid is sampled; DRAIN SHALL otherwise hold.
REQ-018 SHALL transition RELEASE->IDLE unconditionally after one cycle; RELEASE SHALL NOT re-trigger DRAIN.
REQ-019 SHALL, in DRAIN, assert stall_if=stall_id=bubble_ex=1.
REQ-020 SHALL, in RELEASE, deassert all stalls so the fence/system instruction advances.
REQ-021 SHALL, in IDLE, assert stall_if=stall_id=bubble_ex=1 combinationally in the same cycle as load-use or store_full.
REQ-022 SHALL apply priority ex_redirect > DRAIN > load-use > store_full.
REQ-023 SHALL, on ex_redirect in any state, give flush_id=1, bubble_ex=1, stall_if=stall_id=0 that cycle and next state IDLE.
REQ-024 SHALL update st_count +1 on st_issue only, -1 on st_ack only, and hold it when both or neither assert.
REQ-025 SHALL hold st_count and set proto_err on st_issue-only at MAX_OUTSTANDING or st_ack-only at 0.
REQ-026 SHALL clear proto_err only by reset.
REQ-027 SHALL decode drain_busy from the registered state only, with no combinational input path.

Reset
REQ-028 SHALL, while rst=1 (async), force state=IDLE, st_count=0 and proto_err=0.
REQ-029 SHALL, while rst=1, drive stall_if=stall_id=bubble_ex=flush_id=0 and drain_busy=0.
REQ-030 SHALL, when reset asserts mid-DRAIN, abandon the drain; first post-reset cycle is IDLE with count 0.

Verification
REQ-031 SHALL cover load-use: ex lw rd=5 valid, id add rs1=5 has_rs1=1 -> stall_if=stall_id=bubble_ex=1 same cycle; ex_rd=0 -> no stall.
REQ-032 SHALL cover store backpressure: 4 st_issue, no ack, id store -> stall until one st_ack, st_count 4->3, stall drops same cycle.
REQ-033 SHALL cover fence drain: st_count=2, id_is_fence -> DRAIN, drain_busy=1; two acks -> RELEASE one cycle with stalls 0 -> IDLE.
REQ-034 SHALL cover redirect priority: ex_redirect with load-use and id_is_fence together -> flush_id=1, stall_if=0, state stays IDLE.
REQ-035 SHALL cover counter edges: simultaneous issue+ack at 4 -> count 4, proto_err 0; ack at 0 -> count 0, proto_err=1 until rst.
REQ-036 SHALL cover async reset mid-DRAIN with st_count=3 -> immediately IDLE, count 0, all outputs 0.
